instruction_fetch_unit: RTL

Upstream neighbour of the control unit in the 24-bit CPU. Owns the PC and fetches 24-bit instructions from instruction memory over a req/ready handshake. Presents the captured instruction and its 4-bit opcode (bits [23:20]) with a valid flag to the decoder/control unit. Applies branch redirects from the datapath when it advances the PC.

---
 rtl/cpu24_pkg.sv | 23 ++
 rtl/ifu_pc_next.sv | 16 +
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU: opcodes, instruction field positions and fetch-unit states.
package cpu24_pkg;

    localparam int INSTR_W_DEFAULT = 24;

    localparam int OPCODE_MSB = 23;
    localparam int OPCODE_LSB = 20;

    localparam logic [3:0] OP_RTYPE  = 4'b0110;
    localparam logic [3:0] OP_ADDI   = 4'b0001;
    localparam logic [3:0] OP_LS     = 4'b0010;
    localparam logic [3:0] OP_SS     = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } ifuState_t;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC arithmetic for the fetch unit: PC+1 and the taken-branch target, both wrapping at ADDR_W bits.
module ifu_pc_next #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchOffset,
    output logic [ADDR_W-1:0] pcPlus1,
    output logic [ADDR_W-1:0] pcNext
);

    assign pcPlus1 = pc + ADDR_W'(1);
    // Offset is two's complement relative to PC+1; plain modular add handles both directions.
    assign pcNext  = branchTaken ? (pcPlus1 + branchOffset) : pcPlus1;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake and presents instructions to decode.
// Optional HALT opcode support is enabled with `define IFU_HALT_EN.
//
// state  | meaning
// IDLE   | one cycle after reset release before the first fetch
// FETCH  | imem_req held at imem_addr until imem_ready
// ISSUE  | instruction presented with InstrValid; waits for Stall=0 to advance
// HALTED | HALT opcode issued; fetch stopped until reset (IFU_HALT_EN only)
module instruction_fetch_unit
    import cpu24_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Stall,
    input  logic               Branch,
    input  logic               Zero,
    input  logic [ADDR_W-1:0]  BranchOffset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] Instr,
    output logic [3:0]         Opcode,
    output logic               InstrValid,
    output logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  PCPlus1,
    output logic               Halted
);

    ifuState_t          state;
    logic [ADDR_W-1:0]  pcReg;
    logic [ADDR_W-1:0]  pcNext;
    logic [INSTR_W-1:0] instrReg;
    logic               validReg;
    logic               reqReg;
    logic [ADDR_W-1:0]  addrReg;

    ifu_pc_next #(
        .ADDR_W(ADDR_W)
    ) uPcNext (
        .pc          (pcReg),
        .branchTaken (Branch & Zero),
        .branchOffset(BranchOffset),
        .pcPlus1     (PCPlus1),
        .pcNext      (pcNext)
    );

`ifdef IFU_HALT_EN
    logic haltReg;
`endif

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            pcReg    <= RESET_PC;
            instrReg <= '0;
            validReg <= 1'b0;
            reqReg   <= 1'b0;
            addrReg  <= '0;
`ifdef IFU_HALT_EN
            haltReg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    reqReg  <= 1'b1;
                    addrReg <= pcReg;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instrReg <= imem_rdata;
                        reqReg   <= 1'b0;
                        validReg <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!Stall) begin
`ifdef IFU_HALT_EN
                        if (Opcode == OP_HALT) begin
                            validReg <= 1'b0;
                            haltReg  <= 1'b1;
                            state    <= HALTED;
                        end else
`endif
                        begin
                            // Request the next address in the same edge that updates PC.
                            pcReg    <= pcNext;
                            addrReg  <= pcNext;
                            reqReg   <= 1'b1;
                            validReg <= 1'b0;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    validReg <= 1'b0;
                    reqReg   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = reqReg;
    assign imem_addr  = addrReg;
    assign Instr      = instrReg;
    assign Opcode     = instrReg[OPCODE_MSB:OPCODE_LSB];
    assign InstrValid = validReg;
    assign PC         = pcReg;

`ifdef IFU_HALT_EN
    assign Halted = haltReg;
`else
    assign Halted = 1'b0;
`endif

endmodule
